// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares NUM_CDB wakeup lanes among NUM_REQ FU result registers.
// Each FU result is buffered in a per-requester hold register. Up to NUM_CDB
// holds are granted per cycle in round-robin order. The granted results are
// driven on registered wakeup lanes.
// Optional feature macro: CDB_BYPASS_EN. When it is defined, an incoming
// result with an empty hold can be broadcast directly, with 1-edge latency.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

// One broadcast lane register. A lane that is idle or flushed drives all zeros.
module cdb_lane #(
  parameter int TW = 6,
  parameter int VW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          gnt,
  input  logic [TW-1:0] tag_in,
  input  logic [VW-1:0] value_in,
  output logic          wakeup,
  output logic [TW-1:0] tag,
  output logic [VW-1:0] value
);
  // Register the granted result, or clear the lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wakeup <= 1'b0;
      tag    <= '0;
      value  <= '0;
    end else if (flush || !gnt) begin
      wakeup <= 1'b0;
      tag    <= '0;
      value  <= '0;
    end else begin
      wakeup <= 1'b1;
      tag    <= tag_in;
      value  <= value_in;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2,
  parameter int NUM_CDB   = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQ-1:0]                         req_valid,
  input  logic [NUM_REQ-1:0][`ROB_TAG_LEN-1:0]       req_tag,
  input  logic [NUM_REQ-1:0][`XLEN-1:0]              req_value,
  output logic [NUM_REQ-1:0]                         req_ready,
  input  logic                                       flush,
  output logic [NUM_CDB-1:0]                         wakeup,
  output logic [NUM_CDB-1:0][`ROB_TAG_LEN-1:0]       wakeup_tag,
  output logic [NUM_CDB-1:0][`XLEN-1:0]              wakeup_value,
  output logic                                       busy
);
  logic [NUM_REQ-1:0]                    hold_valid;
  logic [NUM_REQ-1:0][`ROB_TAG_LEN-1:0]  hold_tag;
  logic [NUM_REQ-1:0][`XLEN-1:0]         hold_value;
  logic [REQ_IDX_W-1:0]                  rr_ptr;

  logic [NUM_REQ-1:0]                    cand;
  logic [NUM_REQ-1:0][`ROB_TAG_LEN-1:0]  src_tag;
  logic [NUM_REQ-1:0][`XLEN-1:0]         src_value;
  logic [NUM_REQ-1:0]                    grant;
  logic [NUM_REQ-1:0]                    fire;
  logic [NUM_REQ-1:0]                    byp;
  logic [NUM_CDB-1:0]                    lane_gnt;
  logic [NUM_CDB-1:0][`ROB_TAG_LEN-1:0]  lane_tag;
  logic [NUM_CDB-1:0][`XLEN-1:0]         lane_value;
  logic [REQ_IDX_W-1:0]                  last_idx;

`ifdef CDB_BYPASS_EN
  // An empty hold with an incoming result competes using the port values.
  assign cand      = hold_valid | (req_valid & {NUM_REQ{!flush}});
  always_comb begin
    src_tag   = '0;
    src_value = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_tag[i]   = hold_valid[i] ? hold_tag[i]   : req_tag[i];
      src_value[i] = hold_valid[i] ? hold_value[i] : req_value[i];
    end
  end
`else
  assign cand      = hold_valid;
  assign src_tag   = hold_tag;
  assign src_value = hold_value;
`endif

  // Round-robin scan starting at rr_ptr. The k-th grant drives lane k.
  always_comb begin
    int cnt;
    int idx;
    grant      = '0;
    lane_gnt   = '0;
    lane_tag   = '0;
    lane_value = '0;
    last_idx   = rr_ptr;
    cnt        = 0;
    idx        = 0;
    if (!flush) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        idx = (int'(rr_ptr) + j) % NUM_REQ;
        if (cand[idx] && cnt < NUM_CDB) begin
          grant[idx]      = 1'b1;
          lane_gnt[cnt]   = 1'b1;
          lane_tag[cnt]   = src_tag[idx];
          lane_value[cnt] = src_value[idx];
          last_idx        = REQ_IDX_W'(idx);
          cnt++;
        end
      end
    end
  end

  assign req_ready = {NUM_REQ{!flush}} & (~hold_valid | grant);
  assign fire      = req_valid & req_ready;
  // A granted result that had no hold came straight from the port, so it is
  // never written into the hold.
  assign byp       = grant & ~hold_valid;
  assign busy      = |hold_valid;

  // Hold buffers: a handshake refills the hold, and a grant drains it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= '0;
      hold_tag   <= '0;
      hold_value <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush) begin
          hold_valid[i] <= 1'b0;
        end else if (fire[i] && !byp[i]) begin
          hold_valid[i] <= 1'b1;
          hold_tag[i]   <= req_tag[i];
          hold_value[i] <= req_value[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // The round-robin pointer moves past the last granted requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (flush)
      rr_ptr <= '0;
    else if (|grant)
      rr_ptr <= REQ_IDX_W'((int'(last_idx) + 1) % NUM_REQ);
  end

  // One registered output stage per broadcast lane.
  for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
    cdb_lane #(.TW(`ROB_TAG_LEN), .VW(`XLEN)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .gnt      (lane_gnt[k]),
      .tag_in   (lane_tag[k]),
      .value_in (lane_value[k]),
      .wakeup   (wakeup[k]),
      .tag      (wakeup_tag[k]),
      .value    (wakeup_value[k])
    );
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
// dut uses NUM_CDB=2 and dut1 uses NUM_CDB=1.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;
  localparam int TW = `ROB_TAG_LEN;
  localparam int VW = `XLEN;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [3:0]         rv;
  logic [3:0][TW-1:0] rtag;
  logic [3:0][VW-1:0] rval;
  logic [3:0]         ready;
  logic [1:0]         wk;
  logic [1:0][TW-1:0] wtag;
  logic [1:0][VW-1:0] wval;
  logic               busy;

  logic               flush1 = 1'b0;
  logic [3:0]         rv1;
  logic [3:0][TW-1:0] rtag1;
  logic [3:0][VW-1:0] rval1;
  logic [3:0]         ready1;
  logic [0:0]         wk1;
  logic [0:0][TW-1:0] wtag1;
  logic [0:0][VW-1:0] wval1;
  logic               busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4), .REQ_IDX_W(2), .NUM_CDB(2)) dut (
    .clk(clk), .reset(reset), .req_valid(rv), .req_tag(rtag), .req_value(rval),
    .req_ready(ready), .flush(flush), .wakeup(wk), .wakeup_tag(wtag),
    .wakeup_value(wval), .busy(busy));

  cdb_arbiter #(.NUM_REQ(4), .REQ_IDX_W(2), .NUM_CDB(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_tag(rtag1), .req_value(rval1),
    .req_ready(ready1), .flush(flush1), .wakeup(wk1), .wakeup_tag(wtag1),
    .wakeup_value(wval1), .busy(busy1));

  // Advance past the next active edge. Inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rv = '0; rtag = '0; rval = '0; rv1 = '0; rtag1 = '0; rval1 = '0; flush = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
  endtask

  task automatic present_all();
    for (int i = 0; i < 4; i++) begin
      rtag[i] = TW'(i + 1);
      rval[i] = VW'(100 + i);
    end
    rv = 4'hF;
  endtask

  task automatic test_reset();
    apply_reset();
    rv = 4'b0101; rtag[0] = TW'(1); rtag[2] = TW'(2);
    tick();
    rtag[0] = TW'(7); rtag[2] = TW'(8);
    tick();
    rv = '0;
    checks++;
    if (wk !== 2'b11) begin failures++; $display("FAIL pre_reset_wakeup got=%b exp=11", wk); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (wk !== 2'b00) begin failures++; $display("FAIL reset_wakeup got=%b exp=00", wk); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (ready !== 4'hF) begin failures++; $display("FAIL reset_ready got=%b exp=1111", ready); end
    checks++;
    if (wtag !== '0 || wval !== '0) begin failures++; $display("FAIL reset_lane_data tag=%h val=%h exp=0", wtag, wval); end
    @(negedge clk) reset = 1'b1;
    tick();
    present_all();
    tick();
    rv = '0;
    tick();
    checks++;
    if (wtag[0] !== TW'(1) || wtag[1] !== TW'(2)) begin
      failures++; $display("FAIL reset_rr_ptr got=%0d,%0d exp=1,2", wtag[0], wtag[1]);
    end
  endtask

  task automatic test_single();
    apply_reset();
    rv = 4'b0001; rtag[0] = TW'(5); rval[0] = VW'(32'h1234);
    tick();
    rv = '0;
    checks++;
    if (wk !== 2'b00 || busy !== 1'b1) begin
      failures++; $display("FAIL single_capture wakeup=%b busy=%b exp=00/1", wk, busy);
    end
    tick();
    checks++;
    if (wk !== 2'b01) begin failures++; $display("FAIL single_wakeup got=%b exp=01", wk); end
    checks++;
    if (wtag[0] !== TW'(5) || wval[0] !== VW'(32'h1234)) begin
      failures++; $display("FAIL single_lane0 tag=%0d val=%h exp=5/1234", wtag[0], wval[0]);
    end
    checks++;
    if (wtag[1] !== '0 || wval[1] !== '0) begin
      failures++; $display("FAIL single_lane1 tag=%0d val=%h exp=0/0", wtag[1], wval[1]);
    end
  endtask

  task automatic test_all_four();
    apply_reset();
    present_all();
    tick();
    rv = '0;
    checks++;
    if (ready !== 4'b0011) begin failures++; $display("FAIL four_ready got=%b exp=0011", ready); end
    tick();
    checks++;
    if (wk !== 2'b11 || wtag[0] !== TW'(1) || wtag[1] !== TW'(2) || wval[1] !== VW'(101)) begin
      failures++; $display("FAIL four_grant1 wk=%b tags=%0d,%0d val1=%0d exp=11 1,2 101", wk, wtag[0], wtag[1], wval[1]);
    end
    tick();
    checks++;
    if (wk !== 2'b11 || wtag[0] !== TW'(3) || wtag[1] !== TW'(4)) begin
      failures++; $display("FAIL four_grant2 wk=%b tags=%0d,%0d exp=11 3,4", wk, wtag[0], wtag[1]);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL four_busy got=%b exp=0", busy); end
    // Requesters 0 and 2 arrive together. With rr_ptr=0, lane 0 must carry requester 0.
    rv = 4'b0101; rtag[0] = TW'(1); rtag[2] = TW'(3);
    tick();
    rv = '0;
    tick();
    checks++;
    if (wtag[0] !== TW'(1) || wtag[1] !== TW'(3)) begin
      failures++; $display("FAIL four_rr_wrap got=%0d,%0d exp=1,3", wtag[0], wtag[1]);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    rv1 = 4'b1001; rtag1[0] = TW'(10); rtag1[3] = TW'(13);
    tick();
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (wk1 !== 1'b1 || wtag1[0] !== ((n % 2 == 0) ? TW'(10) : TW'(13))) begin
        failures++;
        $display("FAIL fair_seq%0d wk=%b tag=%0d exp=1/%0d", n, wk1, wtag1[0], (n % 2 == 0) ? 10 : 13);
      end
    end
    rv1 = '0;
    tick();
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    rv = 4'b0010; rtag[1] = TW'(11);
    tick();
    rv = '0;
    tick();
    rv = 4'b0110; rtag[1] = TW'(21); rtag[2] = TW'(22);
    tick();
    rv = 4'b0001; rtag[0] = TW'(30); flush = 1'b1;
    #1;
    checks++;
    if (ready !== 4'b0000) begin failures++; $display("FAIL flush_ready got=%b exp=0000", ready); end
    tick();
    flush = 1'b0; rv = '0;
    checks++;
    if (wk !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_clear wk=%b busy=%b exp=00/0", wk, busy);
    end
    tick();
    checks++;
    if (wk !== 2'b00) begin failures++; $display("FAIL flush_nocapture wk=%b exp=00", wk); end
    present_all();
    tick();
    rv = '0;
    tick();
    checks++;
    if (wtag[0] !== TW'(1) || wtag[1] !== TW'(2)) begin
      failures++; $display("FAIL flush_rr_ptr got=%0d,%0d exp=1,2", wtag[0], wtag[1]);
    end
  endtask

`ifdef CDB_BYPASS_EN
  task automatic test_bypass();
    apply_reset();
    rv = 4'b0100; rtag[2] = TW'(9);
    tick();
    rv = '0;
    checks++;
    if (wk !== 2'b01 || wtag[0] !== TW'(9) || busy !== 1'b0) begin
      failures++; $display("FAIL bypass_single wk=%b tag=%0d busy=%b exp=01/9/0", wk, wtag[0], busy);
    end
    rv = 4'b0111; rtag[0] = TW'(1); rtag[1] = TW'(2); rtag[2] = TW'(3);
    tick();
    rv = '0;
    checks++;
    if (wk !== 2'b11 || wtag[0] !== TW'(1) || wtag[1] !== TW'(2) || busy !== 1'b1) begin
      failures++; $display("FAIL bypass_three wk=%b tags=%0d,%0d busy=%b exp=11 1,2 1", wk, wtag[0], wtag[1], busy);
    end
    tick();
    checks++;
    if (wk !== 2'b01 || wtag[0] !== TW'(3) || busy !== 1'b0) begin
      failures++; $display("FAIL bypass_held wk=%b tag=%0d busy=%b exp=01/3/0", wk, wtag[0], busy);
    end
  endtask
`endif

  initial begin
    rv = '0; rtag = '0; rval = '0; rv1 = '0; rtag1 = '0; rval1 = '0;
    test_reset();
    test_fairness();
`ifdef CDB_BYPASS_EN
    test_bypass();
`else
    test_single();
    test_all_four();
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
